// File: rtl/input_port_controller_pkg.sv
// Shared definitions for the input port controller slice.
//   flit_type_e : flit type code carried with each buffer-head flit
//   ivc_state_e : per-input-VC controller state
//   is_head/is_tail : decode helpers for flit types that open/close a packet
package input_port_controller_pkg;

    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10,
        FT_HT   = 2'b11
    } flit_type_e;

    typedef enum logic {
        IVC_IDLE   = 1'b0,
        IVC_ACTIVE = 1'b1
    } ivc_state_e;

    // HEAD and single-flit HT both open a packet.
    function automatic logic is_head(input logic [1:0] t);
        return (t == FT_HEAD) || (t == FT_HT);
    endfunction

    // TAIL and single-flit HT both close a packet.
    function automatic logic is_tail(input logic [1:0] t);
        return (t == FT_TAIL) || (t == FT_HT);
    endfunction

endpackage

// File: rtl/input_port_controller_ivc_fsm.sv
// ivc_fsm: controller for one input VC.
//   Holds IDLE/ACTIVE state, the latched output VC, the VA wait counter and a
//   flag recording whether a flit of the current packet has already fired.
// Ports:
//   clk, rstn           clock, async active-low reset
//   fifo_empty          this VC's input buffer is empty
//   flit_type           type of the flit at the buffer head
//   cand                route-calculator output-VC candidates
//   sel_out_vc          one-hot output VC granted by the VC allocator
//   vc_granted          VC allocation grant strobe
//   credit_avail        per-output-VC credit available
//   sw_grant            switch grant (flit fires)
//   req_vc, prio        VC allocation request mask and aged flag
//   sw_req              switch allocation request
//   xb_vc               output VC this VC would drive through the crossbar
//   vc_active           VC currently holds an output VC
//   err                 per-VC protocol violation seen this cycle
module ivc_fsm
    import input_port_controller_pkg::*;
#(
    parameter int CN     = 6,
    parameter int BYPASS = 1,
    parameter int AGE_W  = 4,
    parameter int AGE_TH = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          fifo_empty,
    input  logic [1:0]    flit_type,
    input  logic [CN-1:0] cand,
    input  logic [CN-1:0] sel_out_vc,
    input  logic          vc_granted,
    input  logic [CN-1:0] credit_avail,
    input  logic          sw_grant,
    output logic [CN-1:0] req_vc,
    output logic          prio,
    output logic          sw_req,
    output logic [CN-1:0] xb_vc,
    output logic          vc_active,
    output logic          err
);

    localparam logic [AGE_W-1:0] AGE_MAX  = '1;
    localparam logic [AGE_W-1:0] AGE_TH_W = AGE_W'(AGE_TH);

    ivc_state_e       state_q, state_d;
    logic [CN-1:0]    out_vc_q, out_vc_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             sent_q, sent_d;
    logic             head_at;
    logic             grant_ok;
    logic             fire;

    assign head_at = !fifo_empty && is_head(flit_type);

    always_comb begin
        state_d   = state_q;
        out_vc_d  = out_vc_q;
        age_d     = age_q;
        sent_d    = sent_q;
        req_vc    = '0;
        sw_req    = 1'b0;
        xb_vc     = '0;
        vc_active = 1'b0;
        err       = 1'b0;
        grant_ok  = 1'b0;
        fire      = 1'b0;

        case (state_q)
            IVC_IDLE: begin
                if (head_at)
                    req_vc = cand;
                grant_ok = vc_granted && (req_vc != '0);

                if (!fifo_empty && !is_head(flit_type))
                    err = 1'b1;
                if (vc_granted && (req_vc == '0))
                    err = 1'b1;
                if (grant_ok && (!$onehot(sel_out_vc) || ((sel_out_vc & ~cand) != '0)))
                    err = 1'b1;

                if (grant_ok) begin
                    state_d  = IVC_ACTIVE;
                    out_vc_d = sel_out_vc;
                    age_d    = '0;
                    sent_d   = 1'b0;
                    if (BYPASS != 0) begin
                        // Grant is usable immediately; the buffer is non-empty
                        // because a request could only be raised with a head present.
                        sw_req = |(sel_out_vc & credit_avail);
                        xb_vc  = sel_out_vc;
                        fire   = sw_grant && sw_req;
                        if (fire) begin
                            sent_d = 1'b1;
                            if (flit_type == FT_HT) begin
                                state_d  = IVC_IDLE;
                                out_vc_d = '0;
                            end
                        end
                    end
                end else if ((req_vc != '0) && (age_q != AGE_MAX)) begin
                    age_d = age_q + 1'b1;
                end
            end

            IVC_ACTIVE: begin
                vc_active = 1'b1;
                xb_vc     = out_vc_q;
                sw_req    = !fifo_empty && |(out_vc_q & credit_avail);
                fire      = sw_grant && sw_req;

                // The packet's own head legitimately sits at the buffer head
                // until it fires; only a head after that is a violation.
                if (head_at && sent_q)
                    err = 1'b1;
                if (vc_granted)
                    err = 1'b1;

                if (fire) begin
                    sent_d = 1'b1;
                    if (is_tail(flit_type)) begin
                        state_d  = IVC_IDLE;
                        out_vc_d = '0;
                    end
                end
            end

            default: state_d = IVC_IDLE;
        endcase

        // Outputs are forced low for as long as reset is held, even though
        // the buffer inputs may still present a head.
        if (!rstn) begin
            req_vc = '0;
            sw_req = 1'b0;
            xb_vc  = '0;
        end
    end

    assign prio = rstn && (age_q >= AGE_TH_W) && (req_vc != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IVC_IDLE;
            out_vc_q <= '0;
            age_q    <= '0;
            sent_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_vc_q <= out_vc_d;
            age_q    <= age_d;
            sent_q   <= sent_d;
        end
    end

endmodule

// File: rtl/input_port_controller.sv
// input_port_controller: per-input-port VC controller of a router.
//   One ivc_fsm per input VC requests output VCs from the VC allocator, holds
//   the granted output VC for the packet, and requests switch traversal when
//   that output VC has credit. The top level builds the crossbar output-VC
//   select and collects protocol errors into a sticky flag.
// Ports:
//   clk, rstn         clock, async active-low reset
//   fifo_empty        [NVC]     per-VC buffer empty
//   flit_type         [2*NVC]   per-VC head flit type
//   candidateOutVC    [NVC*CN]  per-VC output-VC candidates
//   reqVC             [NVC*CN]  per-VC VC allocation request
//   prio              [NVC]     per-VC aged request flag
//   selOutVC          [NVC*CN]  per-VC granted output VC (one-hot)
//   VCgranted         [NVC]     per-VC VA grant strobe
//   credit_avail      [CN]      output VC has a downstream credit
//   swReq             [NVC]     switch allocation request
//   swGrant           [NVC]     one-hot switch grant (flit fire)
//   selXBVC           [CN]      crossbar output-VC select
//   vc_active         [NVC]     VC holds an output VC
//   proto_err                   sticky protocol error
module input_port_controller
    import input_port_controller_pkg::*;
#(
    parameter int NVC    = 4,
    parameter int CN     = 6,
    parameter int BYPASS = 1,
    parameter int AGE_W  = 4,
    parameter int AGE_TH = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NVC-1:0]    fifo_empty,
    input  logic [2*NVC-1:0]  flit_type,
    input  logic [NVC*CN-1:0] candidateOutVC,
    output logic [NVC*CN-1:0] reqVC,
    output logic [NVC-1:0]    prio,
    input  logic [NVC*CN-1:0] selOutVC,
    input  logic [NVC-1:0]    VCgranted,
    input  logic [CN-1:0]     credit_avail,
    output logic [NVC-1:0]    swReq,
    input  logic [NVC-1:0]    swGrant,
    output logic [CN-1:0]     selXBVC,
    output logic [NVC-1:0]    vc_active,
    output logic              proto_err
);

    logic [CN-1:0]  xb_vc [NVC];
    logic [NVC-1:0] vc_err;
    logic           sw_err;

    for (genvar i = 0; i < NVC; i++) begin : g_vc
        ivc_fsm #(
            .CN     (CN),
            .BYPASS (BYPASS),
            .AGE_W  (AGE_W),
            .AGE_TH (AGE_TH)
        ) u_fsm (
            .clk          (clk),
            .rstn         (rstn),
            .fifo_empty   (fifo_empty[i]),
            .flit_type    (flit_type[2*i +: 2]),
            .cand         (candidateOutVC[CN*i +: CN]),
            .sel_out_vc   (selOutVC[CN*i +: CN]),
            .vc_granted   (VCgranted[i]),
            .credit_avail (credit_avail),
            .sw_grant     (swGrant[i]),
            .req_vc       (reqVC[CN*i +: CN]),
            .prio         (prio[i]),
            .sw_req       (swReq[i]),
            .xb_vc        (xb_vc[i]),
            .vc_active    (vc_active[i]),
            .err          (vc_err[i])
        );
    end

    // With a legal one-hot grant the OR reduces to a plain select.
    always_comb begin
        selXBVC = '0;
        for (int i = 0; i < NVC; i++)
            if (swGrant[i])
                selXBVC = selXBVC | xb_vc[i];
    end

    assign sw_err = ((swGrant != '0) && !$onehot(swGrant)) || ((swGrant & ~swReq) != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            proto_err <= 1'b0;
        else if ((vc_err != '0) || sw_err)
            proto_err <= 1'b1;
    end

endmodule

// File: tb/tb_input_port_controller.sv
module tb_input_port_controller;
    import input_port_controller_pkg::*;

    localparam int NVC = 4;
    localparam int CN  = 6;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NVC-1:0]    fifo_empty;
    logic [2*NVC-1:0]  flit_type;
    logic [NVC*CN-1:0] candidateOutVC;
    logic [NVC*CN-1:0] selOutVC;
    logic [NVC-1:0]    VCgranted;
    logic [CN-1:0]     credit_avail;
    logic [NVC-1:0]    swGrant;

    // BYPASS=1 instance
    logic [NVC*CN-1:0] reqVC_b1;
    logic [NVC-1:0]    prio_b1, swReq_b1, act_b1;
    logic [CN-1:0]     selXB_b1;
    logic              err_b1;
    // BYPASS=0 instance
    logic [NVC*CN-1:0] reqVC_b0;
    logic [NVC-1:0]    prio_b0, swReq_b0, act_b0;
    logic [CN-1:0]     selXB_b0;
    logic              err_b0;

    input_port_controller #(.NVC(NVC), .CN(CN), .BYPASS(1), .AGE_W(4), .AGE_TH(8)) u_dut_b1 (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .flit_type(flit_type),
        .candidateOutVC(candidateOutVC), .reqVC(reqVC_b1), .prio(prio_b1),
        .selOutVC(selOutVC), .VCgranted(VCgranted), .credit_avail(credit_avail),
        .swReq(swReq_b1), .swGrant(swGrant), .selXBVC(selXB_b1),
        .vc_active(act_b1), .proto_err(err_b1)
    );

    input_port_controller #(.NVC(NVC), .CN(CN), .BYPASS(0), .AGE_W(4), .AGE_TH(8)) u_dut_b0 (
        .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .flit_type(flit_type),
        .candidateOutVC(candidateOutVC), .reqVC(reqVC_b0), .prio(prio_b0),
        .selOutVC(selOutVC), .VCgranted(VCgranted), .credit_avail(credit_avail),
        .swReq(swReq_b0), .swGrant(swGrant), .selXBVC(selXB_b0),
        .vc_active(act_b0), .proto_err(err_b0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_ent_t;

    sb_ent_t sb[$];
    int      checks = 0;
    int      errors = 0;
    int      age_m;

    task automatic push(input string tag, input logic [31:0] exp);
        sb_ent_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_ent_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic set_vc(input int i, input logic empty, input logic [1:0] t,
                          input logic [CN-1:0] cand, input logic [CN-1:0] sel);
        fifo_empty[i]                 = empty;
        flit_type[2*i +: 2]           = t;
        candidateOutVC[CN*i +: CN]    = cand;
        selOutVC[CN*i +: CN]          = sel;
    endtask

    task automatic clear_inputs();
        fifo_empty     = '1;
        flit_type      = '0;
        candidateOutVC = '0;
        selOutVC       = '0;
        VCgranted      = '0;
        credit_avail   = '0;
        swGrant        = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        // Reset state
        rstn = 1'b0;
        clear_inputs();
        @(negedge clk); #1;
        push("rst_reqVC", 32'h0);     chk(32'(reqVC_b1));
        push("rst_swReq", 32'h0);     chk(32'(swReq_b1));
        push("rst_selXB", 32'h0);     chk(32'(selXB_b1));
        push("rst_active", 32'h0);    chk(32'(act_b1));
        push("rst_err", 32'h0);       chk(32'(err_b1));

        // 1. Single HT on VC0 with bypass grant and switch grant in one cycle
        do_reset();
        @(negedge clk);
        set_vc(0, 1'b0, FT_HT, 6'b000100, 6'b000100);
        VCgranted = 4'b0001; credit_avail = 6'b111111; swGrant = 4'b0001;
        #1;
        push("t1_reqVC", 32'h4);      chk(32'(reqVC_b1));
        push("t1_swReq", 32'h1);      chk(32'(swReq_b1));
        push("t1_selXB", 32'h4);      chk(32'(selXB_b1));
        @(negedge clk);
        set_vc(0, 1'b1, FT_BODY, 6'b0, 6'b0);
        VCgranted = '0; swGrant = '0;
        #1;
        push("t1_stay_idle", 32'h0);  chk(32'(act_b1));
        push("t1_swReq_after", 32'h0); chk(32'(swReq_b1));
        push("t1_err", 32'h0);        chk(32'(err_b1));

        // 2. HEAD, BODY, TAIL on VC1 without bypass
        do_reset();
        @(negedge clk);
        set_vc(1, 1'b0, FT_HEAD, 6'b010000, 6'b010000);
        VCgranted = 4'b0010; credit_avail = 6'b111111;
        #1;
        push("t2_reqVC", 32'h400);    chk(32'(reqVC_b0));
        push("t2_noswReq_grant", 32'h0); chk(32'(swReq_b0));
        @(negedge clk);
        VCgranted = '0; selOutVC = '0; swGrant = 4'b0010;
        #1;
        push("t2_active", 32'h2);     chk(32'(act_b0));
        push("t2_reqVC_active", 32'h0); chk(32'(reqVC_b0));
        push("t2_swReq_head", 32'h2); chk(32'(swReq_b0));
        push("t2_selXB", 32'h10);     chk(32'(selXB_b0));
        @(negedge clk);
        flit_type[3:2] = FT_BODY;
        #1;
        push("t2_swReq_body", 32'h2); chk(32'(swReq_b0));
        @(negedge clk);
        flit_type[3:2] = FT_TAIL;
        #1;
        push("t2_swReq_tail", 32'h2); chk(32'(swReq_b0));
        push("t2_active_tail", 32'h2); chk(32'(act_b0));
        @(negedge clk);
        set_vc(1, 1'b1, FT_BODY, 6'b0, 6'b0);
        swGrant = '0;
        #1;
        push("t2_idle_after_tail", 32'h0); chk(32'(act_b0));
        push("t2_err", 32'h0);        chk(32'(err_b0));

        // 3. Active VC2 starved of credit, then credit returns
        do_reset();
        @(negedge clk);
        set_vc(2, 1'b0, FT_HEAD, 6'b000001, 6'b000001);
        VCgranted = 4'b0100; credit_avail = 6'b000000;
        #1;
        push("t3_swReq_grant", 32'h0); chk(32'(swReq_b1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            VCgranted = '0;
            #1;
            push("t3_swReq_nocredit", 32'h0); chk(32'(swReq_b1));
        end
        credit_avail = 6'b000001;
        #1;
        push("t3_swReq_credit", 32'h4); chk(32'(swReq_b1));
        push("t3_active", 32'h4);     chk(32'(act_b1));
        push("t3_err", 32'h0);        chk(32'(err_b1));

        // 4. VC3 waits for VA; prio from wait count 8, counter saturates at 15
        do_reset();
        @(negedge clk);
        set_vc(3, 1'b0, FT_HEAD, 6'b100000, 6'b0);
        age_m = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            push("t4_prio", (age_m >= 8) ? 32'h8 : 32'h0);
            chk(32'(prio_b1));
            if (age_m < 15) age_m++;
            @(negedge clk);
        end

        // 5a. BODY at head of an idle VC
        do_reset();
        @(negedge clk);
        set_vc(0, 1'b0, FT_BODY, 6'b000010, 6'b0);
        #1;
        push("t5_noreq_body", 32'h0); chk(32'(reqVC_b1));
        @(negedge clk);
        set_vc(0, 1'b1, FT_BODY, 6'b0, 6'b0);
        #1;
        push("t5_err_body", 32'h1);   chk(32'(err_b1));
        repeat (3) @(negedge clk);
        #1;
        push("t5_err_sticky", 32'h1); chk(32'(err_b1));
        // 5b. Grant without a request
        do_reset();
        #1;
        push("t5_err_cleared", 32'h0); chk(32'(err_b1));
        @(negedge clk);
        VCgranted = 4'b0001; selOutVC[5:0] = 6'b000001;
        @(negedge clk);
        VCgranted = '0; selOutVC = '0;
        #1;
        push("t5_err_grant_noreq", 32'h1); chk(32'(err_b1));
        push("t5_grant_ignored", 32'h0);   chk(32'(act_b1));

        // 6. Reset asserted mid-packet on all VCs
        do_reset();
        @(negedge clk);
        set_vc(0, 1'b0, FT_HEAD, 6'b000001, 6'b000001);
        set_vc(1, 1'b0, FT_HEAD, 6'b000010, 6'b000010);
        set_vc(2, 1'b0, FT_HEAD, 6'b000100, 6'b000100);
        set_vc(3, 1'b0, FT_HEAD, 6'b001000, 6'b001000);
        VCgranted = 4'b1111; credit_avail = 6'b111111;
        @(negedge clk);
        VCgranted = '0;
        #1;
        push("t6_all_active", 32'hF); chk(32'(act_b1));
        push("t6_all_swReq", 32'hF);  chk(32'(swReq_b1));
        rstn = 1'b0;
        #1;
        push("t6_rst_active", 32'h0); chk(32'(act_b1));
        push("t6_rst_swReq", 32'h0);  chk(32'(swReq_b1));
        push("t6_rst_reqVC", 32'h0);  chk(32'(reqVC_b1));
        push("t6_rst_prio", 32'h0);   chk(32'(prio_b1));
        push("t6_rst_selXB", 32'h0);  chk(32'(selXB_b1));
        push("t6_rst_err", 32'h0);    chk(32'(err_b1));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        push("t6_new_reqVC", 32'h204081); chk(32'(reqVC_b1));
        push("t6_idle_after_rst", 32'h0); chk(32'(act_b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
